// File: rtl/ex_mdu.sv
// ex_mdu: RV64M multiply/divide unit for the EX stage, shift-add / restoring.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
`ifndef DATA_LEN
`define DATA_LEN 64
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module ex_mdu (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [2:0]           op_i,
  input  logic                 word_i,
  input  logic [`DATA_LEN-1:0] rs1_data_i,
  input  logic [`DATA_LEN-1:0] rs2_data_i,
  input  logic [`REG_IDX-1:0]  rd_idx_i,
  input  logic                 flush_i,
  output logic                 hold_o,
  output logic                 done_o,
  output logic [`DATA_LEN-1:0] result_o,
  output logic [`REG_IDX-1:0]  rd_idx_o,
  output logic                 busy_o
);

  localparam int XLEN = `DATA_LEN;
  localparam int RIDX = `REG_IDX;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [6:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              negp_q, negp_d;
  logic              negr_q, negr_d;
  logic [RIDX-1:0]   rd_q, rd_d;
  logic [RIDX-1:0]   rdo_q, rdo_d;
  logic [2*XLEN-1:0] opa_q, opa_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   res_q, res_d;

  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] v
  );
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Apply the deferred sign and pick the slice the op asks for.
  function automatic logic [XLEN-1:0] fmt(
    input logic [2:0]        op,
    input logic              w,
    input logic              np,
    input logic              nr,
    input logic [2*XLEN-1:0] acc,
    input logic [XLEN-1:0]   quo
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    logic [XLEN-1:0]   res;
    p = np ? -acc : acc;
    q = np ? -quo : quo;
    r = nr ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (!op[2]) begin
      res = (op[1:0] == 2'b00) ? p[XLEN-1:0]
                               : p[2*XLEN-1:XLEN];
    end else begin
      res = op[1] ? r : q;
    end
    if (w) res = sext32(res[31:0]);
    return res;
  endfunction

  logic            is_div;
  logic            a_sgn, b_sgn;
  logic            sa, sb;
  logic            div_zero, div_ovf, mulh_w, special;
  logic [XLEN-1:0] ext_a, ext_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    is_div = op_i[2];
    a_sgn  = is_div ? ~op_i[0] : (op_i != 3'b011);
    b_sgn  = is_div ? ~op_i[0] : ~op_i[1];
    ext_a  = rs1_data_i;
    ext_b  = rs2_data_i;
    if (word_i) begin
      ext_a = a_sgn ? sext32(rs1_data_i[31:0])
                    : {{(XLEN-32){1'b0}}, rs1_data_i[31:0]};
      ext_b = b_sgn ? sext32(rs2_data_i[31:0])
                    : {{(XLEN-32){1'b0}}, rs2_data_i[31:0]};
    end
    sa    = a_sgn & ext_a[XLEN-1];
    sb    = b_sgn & ext_b[XLEN-1];
    mag_a = sa ? -ext_a : ext_a;
    mag_b = sb ? -ext_b : ext_b;

    div_zero = is_div & (ext_b == '0);
    div_ovf  = is_div & ~op_i[0] & (ext_b == '1) &
               (word_i ? (ext_a[31:0] == 32'h8000_0000)
                       : (ext_a == {1'b1, {(XLEN-1){1'b0}}}));
    mulh_w   = word_i & ~is_div & (op_i[1:0] != 2'b00);
    special  = div_zero | div_ovf | mulh_w;

    spec_res = '0;
    if (div_zero) begin
      spec_res = op_i[1] ? ext_a : '1;
    end else if (div_ovf) begin
      spec_res = op_i[1] ? '0 : ext_a;
    end
    if (word_i) spec_res = sext32(spec_res[31:0]);
  end

  logic [XLEN:0]     r_sh;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [2*XLEN-1:0] step_acc, step_opa;
  logic [XLEN-1:0]   step_opb;

  // One iteration: divide shifts the dividend into the remainder,
  // multiply adds the shifted multiplicand when the low bit is set.
  always_comb begin
    r_sh = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    diff = r_sh[XLEN-1:0] - opb_q;
    ge   = (r_sh >= {1'b0, opb_q});
    if (op_q[2]) begin
      step_acc = {{XLEN{1'b0}},
                  ge ? diff : r_sh[XLEN-1:0]};
      step_opa = {{XLEN{1'b0}},
                  opa_q[XLEN-2:0], ge};
      step_opb = opb_q;
    end else begin
      step_acc = acc_q + (opb_q[0] ? opa_q : '0);
      step_opa = opa_q << 1;
      step_opb = opb_q >> 1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    rd_d    = rd_q;
    rdo_d   = rdo_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    res_d   = res_q;
    hold_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          hold_o = 1'b1;
          op_d   = op_i;
          word_d = word_i;
          rd_d   = rd_idx_i;
          negp_d = sa ^ sb;
          negr_d = sa;
          opa_d  = {{XLEN{1'b0}}, mag_a};
          if (is_div && word_i) begin
            opa_d = {{XLEN{1'b0}}, mag_a[31:0], 32'b0};
          end
          opb_d   = mag_b;
          acc_d   = '0;
          cnt_d   = word_i ? 7'd32 : 7'd64;
          state_d = BUSY;
          if (special) begin
            state_d = DONE;
            cnt_d   = '0;
            res_d   = spec_res;
            rdo_d   = rd_idx_i;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!is_div) begin
            state_d = DONE;
            cnt_d   = '0;
            res_d   = fmt(op_i, word_i, sa ^ sb, sa,
                          {{XLEN{1'b0}}, mag_a} *
                          {{XLEN{1'b0}}, mag_b},
                          '0);
            rdo_d   = rd_idx_i;
          end
`endif
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          hold_o = 1'b1;
          acc_d  = step_acc;
          opa_d  = step_opa;
          opb_d  = step_opb;
          cnt_d  = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_d = DONE;
            res_d   = fmt(op_q, word_q, negp_q, negr_q,
                          step_acc, step_opa[XLEN-1:0]);
            rdo_d   = rd_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_o  = ~flush_i;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      rd_q    <= '0;
      rdo_q   <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      rd_q    <= rd_d;
      rdo_q   <= rdo_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign result_o = res_q;
  assign rd_idx_o = rdo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed vectors, random ops against an arithmetic model,
// and flush/reset sequences for ex_mdu.
module tb_ex_mdu;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [2:0]  op_i;
  logic        word_i;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic [4:0]  rd_idx_i;
  logic        flush_i;
  logic        hold_o;
  logic        done_o;
  logic [63:0] result_o;
  logic [4:0]  rd_idx_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mdu dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .op_i       (op_i),
    .word_i     (word_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_idx_i   (rd_idx_i),
    .flush_i    (flush_i),
    .hold_o     (hold_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_idx_o   (rd_idx_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics written directly from the ISA rules.
  function automatic logic [63:0] ref_model(input logic [2:0] op,
      input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ubs, ps;
    logic [127:0]        pu;
    logic signed [63:0]  as6, bs6;
    logic signed [31:0]  as3, bs3;
    logic [31:0]         a3, b3, r3;
    logic [63:0]         r;
    sa  = {{64{a[63]}}, a};
    sb  = {{64{b[63]}}, b};
    ubs = {64'b0, b};
    as6 = a;
    bs6 = b;
    a3  = a[31:0];
    b3  = b[31:0];
    as3 = a3;
    bs3 = b3;
    r   = '0;
    r3  = '0;
    if (!w) begin
      case (op)
        3'd0: r = a * b;
        3'd1: begin ps = sa * sb;  r = ps[127:64]; end
        3'd2: begin ps = sa * ubs; r = ps[127:64]; end
        3'd3: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
        3'd4: begin
          if (b == 0) r = '1;
          else if (a == MIN64 && b == '1) r = a;
          else r = as6 / bs6;
        end
        3'd5: begin
          if (b == 0) r = '1;
          else r = a / b;
        end
        3'd6: begin
          if (b == 0) r = a;
          else if (a == MIN64 && b == '1) r = '0;
          else r = as6 % bs6;
        end
        default: begin
          if (b == 0) r = a;
          else r = a % b;
        end
      endcase
    end else begin
      case (op)
        3'd0: r3 = a3 * b3;
        3'd4: begin
          if (b3 == 0) r3 = '1;
          else if (a3 == 32'h8000_0000 && b3 == '1) r3 = a3;
          else r3 = as3 / bs3;
        end
        3'd5: begin
          if (b3 == 0) r3 = '1;
          else r3 = a3 / b3;
        end
        3'd6: begin
          if (b3 == 0) r3 = a3;
          else if (a3 == 32'h8000_0000 && b3 == '1) r3 = '0;
          else r3 = as3 % bs3;
        end
        3'd7: begin
          if (b3 == 0) r3 = a3;
          else r3 = a3 % b3;
        end
        default: r3 = '0;
      endcase
      r = {{32{r3[31]}}, r3};
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
      input logic [63:0] a, input logic [63:0] b);
    logic bz, ov;
    if (op[2]) begin
      bz = w ? (b[31:0] == 32'h0) : (b == 64'h0);
      ov = !op[0] && (w ? (a[31:0] == 32'h8000_0000 &&
                           b[31:0] == 32'hFFFF_FFFF)
                        : (a == MIN64 && b == '1));
      if (bz || ov) return 1;
    end else begin
      if (w && op != 3'd0) return 1;
`ifdef MDU_FAST_MUL_EN
      return 1;
`endif
    end
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = {$urandom(), $urandom()};
      1: v = 64'($urandom_range(0, 20));
      2: v = -64'($urandom_range(1, 20));
      3: v = '0;
      4: v = '1;
      5: v = MIN64;
      default: v = {32'($urandom()), 32'h8000_0000};
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic w,
      input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
      output logic [63:0] res, output int lat, output logic hold_ok,
      output logic [4:0] rdo);
    @(negedge clk);
    valid_i    = 1'b1;
    op_i       = op;
    word_i     = w;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_idx_i   = rd;
    #1;
    hold_ok = hold_o;
    lat     = -1;
    res     = '0;
    rdo     = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      if (done_o) begin
        lat = k;
        res = result_o;
        rdo = rd_idx_o;
        if (hold_o) hold_ok = 1'b0;
        break;
      end
      if (!hold_o) hold_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [63:0] res, exp;
    int          lat, elat;
    logic        hok, seen;
    logic [4:0]  rdo;

    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65};
    vecs[4]  = '{3'd5, 1'b0, 64'd123, 64'd0, '1, 1};
    vecs[5]  = '{3'd4, 1'b0, MIN64, '1, MIN64, 1};
    vecs[6]  = '{3'd6, 1'b1, 64'h0000_0000_8000_0000, '1, 64'd0, 1};
    vecs[7]  = '{3'd4, 1'b1, 64'h1_0000_0064, 64'd10, 64'd10, 33};
    vecs[8]  = '{3'd1, 1'b0, '1, '1, 64'd0, 65};
    vecs[9]  = '{3'd2, 1'b0, '1, '1, '1, 65};
    vecs[10] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[11] = '{3'd1, 1'b1, 64'd5, 64'd6, 64'd0, 1};
    vecs[12] = '{3'd7, 1'b0, 64'h55, 64'd0, 64'h55, 1};
    vecs[13] = '{3'd7, 1'b1, 64'h8000_0005, 64'h1_0000_0000,
                 64'hFFFF_FFFF_8000_0005, 1};
    vecs[14] = '{3'd5, 1'b0, '1, 64'd1, '1, 65};
    vecs[15] = '{3'd6, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};

    rst        = 1'b1;
    valid_i    = 1'b0;
    op_i       = '0;
    word_i     = 1'b0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    rd_idx_i   = '0;
    flush_i    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hold", 64'(hold_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_rd", 64'(rd_idx_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      elat = vecs[i].lat;
`ifdef MDU_FAST_MUL_EN
      if (!vecs[i].op[2]) elat = 1;
`endif
      run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
             5'(i + 1), res, lat, hok, rdo);
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(elat));
      chk($sformatf("vec%0d_hold", i), 64'(hok), 64'd1);
      chk($sformatf("vec%0d_rd", i), 64'(rdo), 64'(i + 1));
    end

    @(negedge clk);
    #1;
    chk("done_pulse", 64'(done_o), 64'd0);
    chk("idle_after_done", 64'(busy_o), 64'd0);
    chk("res_held", result_o, 64'd1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      exp  = ref_model(op, w, a, b);
      elat = ref_lat(op, w, a, b);
      run_op(op, w, a, b, 5'($urandom_range(0, 31)), res, lat, hok, rdo);
      chk($sformatf("rnd%0d_op%0d_w%0d_res", i, op, w), res, exp);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
      chk($sformatf("rnd%0d_hold", i), 64'(hok), 64'd1);
    end

    run_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd9, res, lat, hok, rdo);
    chk("pre_flush_res", res, 64'd15);

    @(negedge clk);
    valid_i    = 1'b1;
    op_i       = 3'd4;
    word_i     = 1'b0;
    rs1_data_i = 64'd100;
    rs2_data_i = 64'd7;
    rd_idx_i   = 5'd3;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_hold", 64'(hold_o), 64'd0);
    chk("flush_busy_before", 64'(busy_o), 64'd1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_idle", 64'(busy_o), 64'd0);
    chk("flush_hold_after", 64'(hold_o), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      #1;
      if (done_o) seen = 1'b1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_res_kept", result_o, 64'd15);

    @(negedge clk);
    valid_i    = 1'b1;
    op_i       = 3'd4;
    rs1_data_i = 64'd100;
    rs2_data_i = 64'd7;
    rd_idx_i   = 5'd4;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_hold", 64'(hold_o), 64'd0);
    chk("mid_rst_result", result_o, 64'd0);
    chk("mid_rst_rd", 64'(rd_idx_o), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      #1;
      if (done_o) seen = 1'b1;
    end
    chk("mid_rst_no_done", 64'(seen), 64'd0);

    run_op(3'd4, 1'b0, 64'd100, 64'd7, 5'd11, res, lat, hok, rdo);
    chk("post_rst_res", res, 64'd14);
    chk("post_rst_lat", 64'(lat), 64'd65);
    chk("post_rst_rd", 64'(rdo), 64'd11);

    @(negedge clk);
    valid_i    = 1'b1;
    op_i       = 3'd5;
    rs1_data_i = 64'd5;
    rs2_data_i = 64'd0;
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_done_pulse", 64'(done_o), 64'd0);
    chk("flush_done_hold", 64'(hold_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_done_idle", 64'(busy_o), 64'd0);

    @(negedge clk);
    valid_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 3'd4;
    rs2_data_i = 64'd3;
    #1;
    chk("idle_flush_hold", 64'(hold_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("idle_flush_no_accept", 64'(busy_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
